fifo_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of one `fifo` instance between NumReq producers.
- Grants at most one producer per cycle and forwards its data to the FIFO.
- Locks a granted producer for a burst of up to MaxBurst consecutive beats.
- Sits directly in front of `fifo` write_req_i/data_i and consumes its write_valid_o.

---
 rtl/fifo_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares the single write port of
// one FIFO between NumReq producers. A granted producer keeps the port for a
// burst of up to MaxBurst beats, or until it stops requesting, and then
// priority rotates to the next index.
// Optional macro FIFO_WRITE_ARBITER_STATS_EN adds per-producer saturating
// 16-bit beat counters on grant_count_o.
`timescale 1ns/1ps

module fifo_write_arbiter #(
    parameter int NumReq    = 4,
    parameter int EntrySize = 8,
    parameter int MaxBurst  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*EntrySize-1:0]   data_i,
    output logic [NumReq-1:0]             grant_o,
    output logic                          fifo_write_req_o,
    input  logic                          fifo_write_valid_i,
    output logic [EntrySize-1:0]          fifo_data_o
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    output logic [NumReq*16-1:0]          grant_count_o
`endif
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxBurst + 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;

    logic [IdxW-1:0]     scan_start;
    logic [IdxW-1:0]     cand;
    logic [IdxW-1:0]     win_idx;
    logic                found;
    logic [NumReq-1:0]   grant_vec;
    logic [EntrySize-1:0] data_sel;

    // Index increment with wrap from NumReq-1 back to 0.
    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        if (idx == IdxW'(NumReq - 1)) begin
            return '0;
        end
        return idx + IdxW'(1);
    endfunction

    // Find the first requester starting at rr_ptr, or just past the owner when a lock is being released.
    always_comb begin
        scan_start = (state_q == ST_LOCKED) ? next_idx(owner_q) : rr_ptr_q;
        found      = 1'b0;
        win_idx    = '0;
        cand       = scan_start;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Grant selection and next-state: continue a live burst, otherwise arbitrate; a full FIFO freezes everything.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_vec   = '0;
        if (fifo_write_valid_i) begin
            if (state_q == ST_LOCKED && req_i[owner_q]) begin
                grant_vec[owner_q] = 1'b1;
                burst_cnt_d        = burst_cnt_q + CntW'(1);
                if (burst_cnt_q + CntW'(1) == CntW'(MaxBurst)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end
            end else if (found) begin
                grant_vec[win_idx] = 1'b1;
                owner_d            = win_idx;
                burst_cnt_d        = CntW'(1);
                if (MaxBurst > 1) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(win_idx);
                end
            end else if (state_q == ST_LOCKED) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_idx(owner_q);
            end
        end
    end

    // Arbitration state register; reset drops any lock and restarts priority at producer 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Reset masks the grant immediately so nothing reaches the FIFO while rst_i is high.
    assign grant_o          = rst_i ? '0 : grant_vec;
    assign fifo_write_req_o = |grant_o;

    // Forward the granted producer's slice; zero when nobody is granted.
    always_comb begin
        data_sel = '0;
        for (int k = 0; k < NumReq; k++) begin
            data_sel = data_sel | (data_i[k*EntrySize +: EntrySize] & {EntrySize{grant_o[k]}});
        end
    end

    assign fifo_data_o = data_sel;

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [NumReq-1:0][15:0] grant_count_q;

    // Per-producer beat counters, saturating at 0xFFFF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_count_q <= '0;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                if (grant_o[k] && grant_count_q[k] != 16'hFFFF) begin
                    grant_count_q[k] <= grant_count_q[k] + 16'd1;
                end
            end
        end
    end

    assign grant_count_o = grant_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: an abstract owner/beat-count
// model is compared against the DUT every cycle, and directed scenarios pin
// hand-computed grant sequences.
`timescale 1ns/1ps

module tb_fifo_write_arbiter;

    localparam int NumReq    = 4;
    localparam int EntrySize = 8;
    localparam int MaxBurst  = 4;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic [NumReq-1:0]           req_i = '0;
    logic [NumReq*EntrySize-1:0] data_i = '0;
    logic                        fifo_write_valid_i = 1'b1;
    logic [NumReq-1:0]           grant_o;
    logic                        fifo_write_req_o;
    logic [EntrySize-1:0]        fifo_data_o;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [NumReq*16-1:0]        grant_count_o;
`endif

    int checks   = 0;
    int failures = 0;

    // Abstract model: who holds the port, how many beats it has used (0 = nobody locked), who is next in line.
    int m_owner = 0;
    int m_beats = 0;
    int m_next  = 0;

    fifo_write_arbiter #(
        .NumReq(NumReq),
        .EntrySize(EntrySize),
        .MaxBurst(MaxBurst)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .data_i(data_i),
        .grant_o(grant_o),
        .fifo_write_req_o(fifo_write_req_o),
        .fifo_write_valid_i(fifo_write_valid_i),
        .fifo_data_o(fifo_data_o)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        ,
        .grant_count_o(grant_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Producer the model says is granted right now, or -1.
    function automatic int modelGrant();
        int start;
        if (rst_i || !fifo_write_valid_i) return -1;
        if (m_beats > 0 && req_i[m_owner]) return m_owner;
        start = (m_beats > 0) ? (m_owner + 1) % NumReq : m_next;
        for (int i = 0; i < NumReq; i++) begin
            if (req_i[(start + i) % NumReq]) return (start + i) % NumReq;
        end
        return -1;
    endfunction

    task automatic modelStep();
        int g;
        if (rst_i) begin
            m_owner = 0;
            m_beats = 0;
            m_next  = 0;
        end else begin
            g = modelGrant();
            if (g < 0) begin
                if (fifo_write_valid_i && m_beats > 0) begin
                    m_beats = 0;
                    m_next  = (m_owner + 1) % NumReq;
                end
            end else begin
                if (!(m_beats > 0 && g == m_owner)) begin
                    m_owner = g;
                    m_beats = 0;
                end
                m_beats++;
                if (m_beats == MaxBurst) begin
                    m_beats = 0;
                    m_next  = (g + 1) % NumReq;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NumReq-1:0] req, input logic valid, input logic [31:0] data);
        @(posedge clk_i);
        #1;
        req_i              = req;
        fifo_write_valid_i = valid;
        data_i             = data;
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_i              = 1'b1;
        req_i              = '1;
        fifo_write_valid_i = 1'b1;
        #1;
        checkOutput("reset_grant", 32'(grant_o), 32'd0);
        checkOutput("reset_wreq", 32'(fifo_write_req_o), 32'd0);
        checkOutput("reset_data", 32'(fifo_data_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        req_i = '0;
    endtask

    // Model update on every active edge and on asynchronous reset.
    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            modelStep();
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the clock edge.
    initial begin
        int g;
        logic [NumReq-1:0]    exp_grant;
        logic [EntrySize-1:0] exp_data;
        forever begin
            @(negedge clk_i);
            g         = modelGrant();
            exp_grant = '0;
            exp_data  = '0;
            if (g >= 0) begin
                exp_grant[g] = 1'b1;
                exp_data     = data_i[g*EntrySize +: EntrySize];
            end
            checkOutput("model_grant", 32'(grant_o), 32'(exp_grant));
            checkOutput("model_wreq", 32'(fifo_write_req_o), 32'(|exp_grant));
            checkOutput("model_data", 32'(fifo_data_o), 32'(exp_data));
        end
    end

    initial begin
        int seq[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};

        // Idle with no requests, then a single request granted in the same cycle.
        doReset();
        applyStimulus(4'b0000, 1'b1, 32'h44332211);
        #2;
        checkOutput("idle_grant", 32'(grant_o), 32'd0);
        checkOutput("idle_wreq", 32'(fifo_write_req_o), 32'd0);
        applyStimulus(4'b0100, 1'b1, 32'h44332211);
        #2;
        checkOutput("single_grant", 32'(grant_o), 32'b0100);
        checkOutput("single_data", 32'(fifo_data_o), 32'h33);

        // All producers requesting: four-beat bursts rotating 0,1,2,3.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1111, 1'b1, $urandom());
            #2;
            checkOutput($sformatf("rr_grant_%0d", i), 32'(grant_o), 32'd1 << seq[i]);
            checkOutput($sformatf("rr_wreq_%0d", i), 32'(fifo_write_req_o), 32'd1);
        end

        // Owner drops its request mid-burst: released in the same cycle, scan continues past it.
        doReset();
        applyStimulus(4'b0010, 1'b1, $urandom());
        #2;
        checkOutput("own1_beat1", 32'(grant_o), 32'b0010);
        applyStimulus(4'b0010, 1'b1, $urandom());
        #2;
        checkOutput("own1_beat2", 32'(grant_o), 32'b0010);
        applyStimulus(4'b1001, 1'b1, $urandom());
        #2;
        checkOutput("release_to_3", 32'(grant_o), 32'b1000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, 1'b1, $urandom());
            #2;
            checkOutput($sformatf("own3_beat%0d", i + 2), 32'(grant_o), 32'b1000);
        end
        applyStimulus(4'b0011, 1'b1, $urandom());
        #2;
        checkOutput("after3_scan0", 32'(grant_o), 32'b0001);

        // FIFO full mid-burst: held cycles are not beats, burst resumes then rotates.
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0011, 1'b1, $urandom());
            #2;
            checkOutput($sformatf("full_pre%0d", i), 32'(grant_o), 32'b0001);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0011, 1'b0, $urandom());
            #2;
            checkOutput($sformatf("full_hold%0d", i), 32'(grant_o), 32'd0);
            checkOutput($sformatf("full_wreq%0d", i), 32'(fifo_write_req_o), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0011, 1'b1, $urandom());
            #2;
            checkOutput($sformatf("full_post%0d", i), 32'(grant_o), 32'b0001);
        end
        applyStimulus(4'b0011, 1'b1, $urandom());
        #2;
        checkOutput("full_rotate", 32'(grant_o), 32'b0010);

        // Asynchronous reset in the middle of producer 2's burst.
        doReset();
        applyStimulus(4'b0100, 1'b1, $urandom());
        applyStimulus(4'b0100, 1'b1, $urandom());
        applyStimulus(4'b1111, 1'b1, $urandom());
        #1;
        checkOutput("p2_locked", 32'(grant_o), 32'b0100);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_grant", 32'(grant_o), 32'd0);
        checkOutput("async_rst_wreq", 32'(fifo_write_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #2;
        checkOutput("post_rst_first", 32'(grant_o), 32'b0001);
        applyStimulus(4'b0000, 1'b1, $urandom());

`ifdef FIFO_WRITE_ARBITER_STATS_EN
        // Beat counters: fair split, then saturation on producer 0.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1111, 1'b1, $urandom());
        end
        applyStimulus(4'b0000, 1'b1, $urandom());
        #2;
        for (int k = 0; k < NumReq; k++) begin
            checkOutput($sformatf("stats_count%0d", k), 32'(grant_count_o[k*16 +: 16]), 32'd4);
        end
        applyStimulus(4'b0001, 1'b1, $urandom());
        repeat (70000) @(posedge clk_i);
        #1;
        req_i = '0;
        #1;
        checkOutput("stats_sat0", 32'(grant_count_o[15:0]), 32'hFFFF);
        checkOutput("stats_other1", 32'(grant_count_o[31:16]), 32'd4);
`endif

        repeat (2) @(posedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
